// File: rtl/toggle_monitor.sv
// toggle_monitor: checks a free-running toggle input for edges, half-period lock and stalls.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   in_sig            monitored toggle signal
//   clear             clears edge_count and stall_seen
//   rise_pulse        one-cycle pulse per 0->1 transition
//   fall_pulse        one-cycle pulse per 1->0 transition
//   edge_count        total transitions, wraps
//   half_period       latest valid half-period measurement in clk cycles
//   locked, stalled   FSM state flags
//   stall_seen        sticky flag, set on any entry to STALLED
// Define TOGGLE_MONITOR_SYNC_EN to pass in_sig through SYNC_STAGES synchronizer flops;
// otherwise a single capture register is used and SYNC_STAGES is ignored.
module toggle_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_sig,
    input  logic                 clear,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [CNT_WIDTH-1:0] edge_count,
    output logic [CNT_WIDTH-1:0] half_period,
    output logic                 locked,
    output logic                 stalled,
    output logic                 stall_seen
);
`ifdef TOGGLE_MONITOR_SYNC_EN
    localparam int L = SYNC_STAGES;
`else
    // SYNC_STAGES has no effect in this build; the expression keeps L at 1
    localparam int L = SYNC_STAGES - SYNC_STAGES + 1;
`endif
    localparam int MW = $clog2(LOCK_COUNT + 1);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, STALLED} state_t;
    state_t               state, state_nx;
    logic [L-1:0]         sync;
    logic                 d, prev, det, match;
    logic [CNT_WIDTH-1:0] gap, hp_nx;
    logic [MW-1:0]        mc, mc_nx, inc;
    assign d     = sync[L-1];
    assign det   = d ^ prev;
    assign match = gap == half_period;
    // Match count after a measurement in ACQUIRE: a fresh run starts at 1
    assign inc   = (mc == '0) ? MW'(1) : (match ? mc + 1'b1 : MW'(1));
    always_comb begin
        state_nx = state;
        mc_nx    = mc;
        hp_nx    = half_period;
        if (det) begin
            case (state)
                IDLE, STALLED: begin
                    state_nx = ACQUIRE;
                    mc_nx    = '0;
                end
                ACQUIRE: begin
                    hp_nx    = gap;
                    mc_nx    = inc;
                    state_nx = (inc == MW'(LOCK_COUNT)) ? LOCKED : ACQUIRE;
                end
                default: begin
                    state_nx = match ? LOCKED : ACQUIRE;
                    hp_nx    = gap;
                    mc_nx    = match ? mc : MW'(1);
                end
            endcase
        end else if (state != STALLED && gap == CNT_WIDTH'(TIMEOUT)) begin
            state_nx = STALLED;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sync        <= '0;
            prev        <= 1'b0;
            gap         <= '0;
            state       <= IDLE;
            mc          <= '0;
            half_period <= '0;
            edge_count  <= '0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            locked      <= 1'b0;
            stalled     <= 1'b0;
            stall_seen  <= 1'b0;
        end else begin
            // Truncating the concatenation shifts in_sig in and also works for L == 1
            sync        <= L'({sync, in_sig});
            prev        <= d;
            gap         <= det ? CNT_WIDTH'(1) : (&gap ? gap : gap + 1'b1);
            state       <= state_nx;
            mc          <= mc_nx;
            half_period <= hp_nx;
            edge_count  <= clear ? CNT_WIDTH'(det) : edge_count + CNT_WIDTH'(det);
            rise_pulse  <= det & d;
            fall_pulse  <= det & ~d;
            locked      <= state_nx == LOCKED;
            stalled     <= state_nx == STALLED;
            stall_seen  <= (state_nx == STALLED && state != STALLED) | (stall_seen & ~clear);
        end
    end
endmodule

// File: doc/toggle_monitor.md
# toggle_monitor

Downstream consumer and checker for a free-running toggle source. Samples a single-bit toggling input, detects rising and falling transitions, counts them, measures the half-period in clk cycles, declares lock once the half-period is stable, and flags a stall when the input stops toggling. Used in bring-up and self-test logic to confirm that a toggle stage is alive and running at the expected rate.

## Interface
- SYNC_STAGES, 2: synchronizer depth on in_sig, ≥2; used only when TOGGLE_MONITOR_SYNC_EN is defined.
- CNT_WIDTH, 16: width of edge_count, half_period and the internal gap counter.
- LOCK_COUNT, 4: consecutive equal half-period measurements required for lock, ≥2.
- TIMEOUT, 16: cycles without a transition before a stall is declared, 1 ≤ TIMEOUT < 2^CNT_WIDTH − 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_sig  in  1  monitored toggle signal.
- clear  in  1  clears edge_count and stall_seen.
- rise_pulse  out  1  one-cycle pulse per detected 0→1 transition.
- fall_pulse  out  1  one-cycle pulse per detected 1→0 transition.
- edge_count  out  CNT_WIDTH  total detected transitions; wraps modulo 2^CNT_WIDTH.
- half_period  out  CNT_WIDTH  most recent valid half-period measurement.
- locked  out  1  high in LOCKED.
- stalled  out  1  high in STALLED.
- stall_seen  out  1  sticky; set on any entry to STALLED.

## Operation
- Input path: in_sig passes through L register stages to give d, where L = SYNC_STAGES with the macro and L = 1 without it. prev is d delayed one cycle. Detection means d != prev.
- Reset value of every flop is 0, including the synchronizer, d, prev, all outputs and the FSM (IDLE). If in_sig is held at 1 through reset, one rise is detected after release; this is intentional.
- Gap counter: 0 at reset. On detection it loads 1; otherwise it increments, saturating at 2^CNT_WIDTH − 1. The measured value is the gap value at the detecting edge.
- match_cnt: counts consecutive equal measurements; width ceil(log2(LOCK_COUNT+1)).
- FSM states and transitions:
  - IDLE: on detection go to ACQUIRE with match_cnt = 0. half_period is not updated.
  - ACQUIRE:
    - On detection with match_cnt = 0: half_period ← measured, match_cnt ← 1.
    - On detection with match_cnt > 0: if measured == half_period, match_cnt increments; otherwise match_cnt ← 1. half_period ← measured in both cases.
    - Go to LOCKED on the detection that brings match_cnt to LOCK_COUNT.
  - LOCKED: on detection with measured != half_period, go to ACQUIRE with half_period ← measured and match_cnt ← 1. On an equal measurement, stay in LOCKED.
  - Any state except STALLED: if gap == TIMEOUT and there is no detection that cycle, go to STALLED.
  - STALLED: on detection go to ACQUIRE with match_cnt = 0. The stale gap is discarded.
- edge_count increments on every detection in every state.
- clear vs. detection in the same cycle: edge_count ← 1.
- clear vs. stall entry in the same cycle: stall_seen ← 1 (set wins).
- reset mid-operation: all state returns to reset values on the next edge. Pulses already in flight are dropped.

## Timing
- All outputs are registered.
- in_sig sampled at edge k → rise_pulse/fall_pulse high for the one cycle after edge k+L. edge_count and half_period update on that same edge.
- locked rises and falls on the edge that performs the LOCKED transition; stalled behaves the same for STALLED.
- An input toggling every cycle gives detections every cycle, measured = 1, and locked after the (LOCK_COUNT+1)-th detection.
- rise_pulse and fall_pulse are never high together.

## Configuration
- TOGGLE_MONITOR_SYNC_EN:
  - Defined: L = SYNC_STAGES, for in_sig asynchronous to clk.
  - Undefined: L = 1 with a single capture register, for an in_sig generated on clk. SYNC_STAGES is ignored.

## Test plan
- Upstream toggle on the same clk, macro undefined, defaults: after release, alternating rise/fall pulses every cycle, half_period = 1, locked high after the 5th detection, edge_count = 100 after 100 detections.
- in_sig toggled every 3 cycles: half_period = 3, locked after 5 detections. Then hold in_sig constant: stalled goes high when gap reaches 16 without a detection, locked goes low, stall_seen = 1.
- Resume toggling every 3 cycles after a stall: the first detection returns to ACQUIRE without updating half_period, and locked returns after 4 more detections.
- Locked at period 3, insert one 5-cycle half-period: locked drops on that detection with half_period = 5, then relocks after 4 further equal measurements.
- clear asserted on a detection cycle: edge_count = 1 on the next cycle. clear asserted with no stall pending: stall_seen = 0.
- Macro defined with SYNC_STAGES = 3: pulse latency is 3 cycles from sampling. Reset asserted mid-lock: all outputs read 0 the cycle after the reset edge.
